// File: rtl/wfg_stim_sine_sweep_ctrl_pkg.sv
// Shared types and register map for the sine stimulus sweep controller.
package wfg_stim_sine_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WR_INC = 3'd1,
    ST_WR_EN  = 3'd2,
    ST_DWELL  = 3'd3,
    ST_WR_DIS = 3'd4
  } sweep_state_e;

  localparam logic [31:0] WFG_SINE_CTRL_ADDR = 32'h1;
  localparam logic [31:0] WFG_SINE_INC_ADDR  = 32'h2;
  localparam int          DWELL_W            = 24;

  // A dwell of zero still spends one cycle on the current INC value.
  function automatic logic [DWELL_W-1:0] dwell_eff(input logic [DWELL_W-1:0] d);
    return (d == '0) ? DWELL_W'(1) : d;
  endfunction

endpackage

// File: rtl/wfg_stim_sine_sweep_ctrl_if.sv
// Wishbone write-only bus segment between the sweep controller and the sine register slave.
interface wfg_stim_sine_sweep_ctrl_if #(
  parameter int BUSW = 32
);
  logic              cyc;
  logic              stb;
  logic              we;
  logic [BUSW/8-1:0] sel;
  logic [BUSW-1:0]   adr;
  logic [BUSW-1:0]   dat;
  logic              ack;

  modport master (output cyc, stb, we, sel, adr, dat, input ack);
  modport slave  (input cyc, stb, we, sel, adr, dat, output ack);
endinterface

// File: rtl/wfg_stim_sine_sweep_ctrl_wb_master_wr.sv
// Single-write Wishbone master: holds cyc/stb while req_i is high until ack,
// then forces one idle gap cycle so a trailing slave ack is never mistaken for a new one.
module wfg_wb_master_wr #(
  parameter int BUSW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_i,
  input  logic [BUSW-1:0] addr_i,
  input  logic [BUSW-1:0] data_i,
  output logic            ack_o,
  output logic            done_o,
  wfg_stim_sine_sweep_ctrl_if.master wb
);

  logic gap_q;
  logic gap_d;
  logic stb;

  assign stb    = req_i && !gap_q;
  assign ack_o  = stb && wb.ack;
  assign gap_d  = ack_o;
  assign done_o = gap_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_q <= 1'b0;
    end else begin
      gap_q <= gap_d;
    end
  end

  assign wb.cyc = stb;
  assign wb.stb = stb;
  assign wb.we  = stb;
  assign wb.sel = stb ? '1 : '0;
  assign wb.adr = stb ? addr_i : '0;
  assign wb.dat = stb ? data_i : '0;

endmodule

// File: rtl/wfg_stim_sine_sweep_ctrl.sv
// Sweeps the sine generator's phase increment: writes INC, enables, dwells,
// steps INC by a signed delta, and finally disables the generator.
module wfg_stim_sine_sweep_ctrl
  import wfg_stim_sine_pkg::*;
#(
  parameter int          BUSW      = 32,
  parameter logic [31:0] INC_ADDR  = WFG_SINE_INC_ADDR,
  parameter logic [31:0] CTRL_ADDR = WFG_SINE_CTRL_ADDR
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_ni,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [15:0]        inc_start_i,
  input  logic [15:0]        inc_step_i,
  input  logic [15:0]        steps_i,
  input  logic [DWELL_W-1:0] dwell_i,
  wfg_stim_sine_sweep_ctrl_if.master wbm,
  output logic               busy_o,
  output logic               done_o,
  output logic [15:0]        cur_inc_o,
  output logic [15:0]        step_cnt_o
);

  sweep_state_e       state_q, state_d;
  logic [15:0]        inc_q, inc_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [15:0]        step_q, step_d;
  logic [15:0]        steps_q, steps_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
  logic               abort_q, abort_d;
  logic               done_q, done_d;
  logic [15:0]        cur_inc_q, cur_inc_d;

  logic               wr_req;
  logic [BUSW-1:0]    wr_addr;
  logic [BUSW-1:0]    wr_data;
  logic               wr_ack;
  logic               wr_done;
  logic               abort_any;

  assign abort_any = abort_q || abort_i;

  always_comb begin
    state_d     = state_q;
    inc_d       = inc_q;
    cnt_d       = cnt_q;
    step_d      = step_q;
    steps_d     = steps_q;
    dwell_d     = dwell_q;
    dwell_cnt_d = dwell_cnt_q;
    abort_d     = abort_q;
    done_d      = 1'b0;
    cur_inc_d   = cur_inc_q;
    wr_req      = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;

    if (state_q != ST_IDLE && abort_i) abort_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        abort_d = 1'b0;
        if (start_i && !abort_i) begin
          inc_d   = inc_start_i;
          step_d  = inc_step_i;
          steps_d = steps_i;
          dwell_d = dwell_i;
          cnt_d   = '0;
          state_d = ST_WR_INC;
        end
      end
      ST_WR_INC: begin
        wr_req  = 1'b1;
        wr_addr = BUSW'(INC_ADDR);
        wr_data = BUSW'(inc_q);
        if (wr_ack) cur_inc_d = inc_q;
        // Advance only after the gap cycle so DWELL starts on a clean bus.
        if (wr_done) begin
          if (abort_any) begin
            state_d = ST_WR_DIS;
          end else if (cnt_q == '0) begin
            state_d = ST_WR_EN;
          end else begin
            state_d     = ST_DWELL;
            dwell_cnt_d = dwell_eff(dwell_q);
          end
        end
      end
      ST_WR_EN: begin
        wr_req  = 1'b1;
        wr_addr = BUSW'(CTRL_ADDR);
        wr_data = BUSW'(1);
        if (wr_done) begin
          if (abort_any) begin
            state_d = ST_WR_DIS;
          end else begin
            state_d     = ST_DWELL;
            dwell_cnt_d = dwell_eff(dwell_q);
          end
        end
      end
      ST_DWELL: begin
        if (abort_any) begin
          state_d = ST_WR_DIS;
        end else if (dwell_cnt_q == DWELL_W'(1)) begin
          if (cnt_q == steps_q) begin
            state_d = ST_WR_DIS;
          end else begin
            inc_d   = inc_q + step_q;
            cnt_d   = cnt_q + 16'd1;
            state_d = ST_WR_INC;
          end
        end else begin
          dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
        end
      end
      ST_WR_DIS: begin
        wr_req  = 1'b1;
        wr_addr = BUSW'(CTRL_ADDR);
        wr_data = '0;
        if (wr_ack) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q     <= ST_IDLE;
      inc_q       <= '0;
      cnt_q       <= '0;
      step_q      <= '0;
      steps_q     <= '0;
      dwell_q     <= '0;
      dwell_cnt_q <= '0;
      abort_q     <= 1'b0;
      done_q      <= 1'b0;
      cur_inc_q   <= '0;
    end else begin
      state_q     <= state_d;
      inc_q       <= inc_d;
      cnt_q       <= cnt_d;
      step_q      <= step_d;
      steps_q     <= steps_d;
      dwell_q     <= dwell_d;
      dwell_cnt_q <= dwell_cnt_d;
      abort_q     <= abort_d;
      done_q      <= done_d;
      cur_inc_q   <= cur_inc_d;
    end
  end

  wfg_wb_master_wr #(.BUSW(BUSW)) u_wr (
    .clk    (wb_clk_i),
    .rst_n  (wb_rst_ni),
    .req_i  (wr_req),
    .addr_i (wr_addr),
    .data_i (wr_data),
    .ack_o  (wr_ack),
    .done_o (wr_done),
    .wb     (wbm)
  );

  assign busy_o     = (state_q != ST_IDLE);
  assign done_o     = done_q;
  assign cur_inc_o  = cur_inc_q;
  assign step_cnt_o = cnt_q;

endmodule

// File: tb/tb_wfg_stim_sine_sweep_ctrl.sv
// Directed bench for the sine sweep controller with a small register-slave model.
module tb_wfg_stim_sine_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] inc_start = '0;
  logic [15:0] step = '0;
  logic [15:0] steps = '0;
  logic [23:0] dwell = '0;
  logic        busy;
  logic        done;
  logic [15:0] cur_inc;
  logic [15:0] step_cnt;

  wfg_stim_sine_sweep_ctrl_if #(.BUSW(32)) wb ();

  wfg_stim_sine_sweep_ctrl #(
    .BUSW      (32),
    .INC_ADDR  (32'h2),
    .CTRL_ADDR (32'h1)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_ni   (rst_n),
    .start_i     (start),
    .abort_i     (abort),
    .inc_start_i (inc_start),
    .inc_step_i  (step),
    .steps_i     (steps),
    .dwell_i     (dwell),
    .wbm         (wb),
    .busy_o      (busy),
    .done_o      (done),
    .cur_inc_o   (cur_inc),
    .step_cnt_o  (step_cnt)
  );

  always #5 clk = ~clk;

  // Register slave: acks one cycle after each sampled stb (plus ack_delay stall cycles).
  int          ack_delay = 0;
  int          hold;
  logic        ack_q;
  logic [31:0] reg_ctrl;
  logic [31:0] reg_inc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q    <= 1'b0;
      hold     <= 0;
      reg_ctrl <= '0;
      reg_inc  <= '0;
    end else begin
      ack_q <= wb.cyc && wb.stb && (hold >= ack_delay);
      hold  <= (wb.cyc && wb.stb) ? hold + 1 : 0;
      if (wb.cyc && wb.stb && wb.we && wb.sel == 4'hF) begin
        if (wb.adr == 32'h1) reg_ctrl <= wb.dat;
        else if (wb.adr == 32'h2) reg_inc <= wb.dat;
      end
    end
  end
  assign wb.ack = ack_q;

  // Bus monitor: logs each acknowledged write with the cycle its stb rose.
  int          cyc_no = 0;
  int          cur_start = 0;
  logic        prev_stb = 1'b0;
  int          done_cnt = 0;
  logic [31:0] log_adr[$];
  logic [31:0] log_dat[$];
  int          log_start[$];

  always @(posedge clk) cyc_no <= cyc_no + 1;

  always @(negedge clk) begin
    if (wb.stb && !prev_stb) cur_start = cyc_no;
    if (wb.stb && wb.ack) begin
      log_adr.push_back(wb.adr);
      log_dat.push_back(wb.dat);
      log_start.push_back(cur_start);
    end
    if (done) done_cnt = done_cnt + 1;
    prev_stb = wb.stb;
  end

  int n_tests = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0]      inc_start;
    logic [15:0]      step;
    logic [15:0]      steps;
    logic [23:0]      dwell;
    int               n_wr;
    logic [7:0][31:0] exp_wr;   // {adr[15:0], dat[15:0]}
    logic [15:0]      exp_cur;
    logic [15:0]      exp_cnt;
    bit               poke;     // pulse start again while busy
  } vec_t;

  vec_t v[4];

  task automatic wait_idle(input string name);
    bit found = 1'b0;
    for (int c = 0; c < 2000 && !found; c++) begin
      @(negedge clk);
      if (!busy) found = 1'b1;
    end
    if (found) check({name, "_done_at_idle"}, done, 1);
    else       check({name, "_idle_timeout"}, busy, 0);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_vector(input int idx, input vec_t tv);
    int b;
    int d0;
    int n;
    int deff;
    string nm;
    nm = $sformatf("vec%0d", idx);
    inc_start = tv.inc_start;
    step      = tv.step;
    steps     = tv.steps;
    dwell     = tv.dwell;
    ack_delay = 0;
    b  = log_adr.size();
    d0 = done_cnt;
    pulse_start();
    check({nm, "_start_busy"}, busy, 1);
    check({nm, "_start_stb"}, wb.stb, 1);
    if (tv.poke) begin
      repeat (2) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_idle(nm);
    repeat (3) @(negedge clk);
    n = log_adr.size() - b;
    deff = (tv.dwell == 0) ? 1 : int'(tv.dwell);
    check({nm, "_n_writes"}, n, tv.n_wr);
    for (int i = 0; i < tv.n_wr && i < n; i++) begin
      check($sformatf("%s_write%0d", nm, i), {log_adr[b+i][15:0], log_dat[b+i][15:0]}, tv.exp_wr[i]);
      if (i > 0)
        check($sformatf("%s_spacing%0d", nm, i), log_start[b+i] - log_start[b+i-1],
              (i == 1) ? 3 : deff + 3);
    end
    check({nm, "_cur_inc"}, cur_inc, tv.exp_cur);
    check({nm, "_step_cnt"}, step_cnt, tv.exp_cnt);
    check({nm, "_slave_inc"}, reg_inc, {16'h0, tv.exp_cur});
    check({nm, "_slave_en"}, reg_ctrl, 0);
    check({nm, "_done_pulses"}, done_cnt - d0, 1);
    $display("[TB] %s start=%h step=%h steps=%0d dwell=%0d writes=%0d", nm, tv.inc_start, tv.step,
             tv.steps, tv.dwell, n);
  endtask

  initial begin
    int b;
    int d0;
    bit seen;

    v[0].inc_start = 16'h1000; v[0].step = 16'h0100; v[0].steps = 16'd3; v[0].dwell = 24'd10;
    v[0].n_wr = 6; v[0].exp_cur = 16'h1300; v[0].exp_cnt = 16'd3; v[0].poke = 1'b0;
    v[0].exp_wr = '0;
    v[0].exp_wr[0] = 32'h0002_1000; v[0].exp_wr[1] = 32'h0001_0001;
    v[0].exp_wr[2] = 32'h0002_1100; v[0].exp_wr[3] = 32'h0002_1200;
    v[0].exp_wr[4] = 32'h0002_1300; v[0].exp_wr[5] = 32'h0001_0000;

    v[1].inc_start = 16'h0080; v[1].step = 16'hFF00; v[1].steps = 16'd1; v[1].dwell = 24'd2;
    v[1].n_wr = 4; v[1].exp_cur = 16'hFF80; v[1].exp_cnt = 16'd1; v[1].poke = 1'b0;
    v[1].exp_wr = '0;
    v[1].exp_wr[0] = 32'h0002_0080; v[1].exp_wr[1] = 32'h0001_0001;
    v[1].exp_wr[2] = 32'h0002_FF80; v[1].exp_wr[3] = 32'h0001_0000;

    v[2].inc_start = 16'hFFF0; v[2].step = 16'h0020; v[2].steps = 16'd2; v[2].dwell = 24'd1;
    v[2].n_wr = 5; v[2].exp_cur = 16'h0030; v[2].exp_cnt = 16'd2; v[2].poke = 1'b0;
    v[2].exp_wr = '0;
    v[2].exp_wr[0] = 32'h0002_FFF0; v[2].exp_wr[1] = 32'h0001_0001;
    v[2].exp_wr[2] = 32'h0002_0010; v[2].exp_wr[3] = 32'h0002_0030;
    v[2].exp_wr[4] = 32'h0001_0000;

    v[3].inc_start = 16'h0500; v[3].step = 16'h0007; v[3].steps = 16'd0; v[3].dwell = 24'd0;
    v[3].n_wr = 3; v[3].exp_cur = 16'h0500; v[3].exp_cnt = 16'd0; v[3].poke = 1'b1;
    v[3].exp_wr = '0;
    v[3].exp_wr[0] = 32'h0002_0500; v[3].exp_wr[1] = 32'h0001_0001;
    v[3].exp_wr[2] = 32'h0001_0000;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_cyc", wb.cyc, 0);
    check("rst_stb", wb.stb, 0);
    check("rst_we", wb.we, 0);
    check("rst_sel", wb.sel, 0);
    check("rst_adr", wb.adr, 0);
    check("rst_dat", wb.dat, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cur_inc", cur_inc, 0);
    check("rst_step_cnt", step_cnt, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 4; i++) run_vector(i, v[i]);

    // start together with abort is dropped
    inc_start = 16'h1000; step = 16'h0100; steps = 16'd3; dwell = 24'd10;
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("start_abort_busy", busy, 0);
    check("start_abort_stb", wb.stb, 0);
    $display("[TB] start+abort together: busy=%0d", busy);

    // Abort during the DWELL after the second INC write
    b = log_adr.size();
    d0 = done_cnt;
    pulse_start();
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (log_adr.size() - b >= 3) seen = 1'b1;
    end
    check("abd_reached_dwell", log_adr.size() - b, 3);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abd_next_stb", wb.stb, 1);
    check("abd_next_adr", wb.adr, 32'h1);
    check("abd_next_dat", wb.dat, 32'h0);
    wait_idle("abd");
    repeat (3) @(negedge clk);
    check("abd_n_writes", log_adr.size() - b, 4);
    if (log_adr.size() - b >= 4)
      check("abd_last_write", {log_adr[b+3][15:0], log_dat[b+3][15:0]}, 32'h0001_0000);
    check("abd_step_cnt", step_cnt, 1);
    check("abd_cur_inc", cur_inc, 16'h1100);
    check("abd_done_pulses", done_cnt - d0, 1);
    check("abd_slave_en", reg_ctrl, 0);
    $display("[TB] abort in dwell: writes=%0d step_cnt=%0d", log_adr.size() - b, step_cnt);

    // Abort in WR_INC while the slave stalls its ack
    ack_delay = 3;
    b = log_adr.size();
    d0 = done_cnt;
    pulse_start();
    @(negedge clk);
    check("abs_in_inc_stb", wb.stb, 1);
    check("abs_in_inc_adr", wb.adr, 32'h2);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abs_still_inc", wb.adr, 32'h2);
    wait_idle("abs");
    repeat (3) @(negedge clk);
    check("abs_n_writes", log_adr.size() - b, 2);
    if (log_adr.size() - b >= 2) begin
      check("abs_write0", {log_adr[b][15:0], log_dat[b][15:0]}, 32'h0002_1000);
      check("abs_write1", {log_adr[b+1][15:0], log_dat[b+1][15:0]}, 32'h0001_0000);
    end
    check("abs_cur_inc", cur_inc, 16'h1000);
    check("abs_done_pulses", done_cnt - d0, 1);
    check("abs_slave_en", reg_ctrl, 0);
    $display("[TB] abort with stalled ack: writes=%0d", log_adr.size() - b);
    ack_delay = 0;

    // Asynchronous reset mid-write
    pulse_start();
    check("rmw_stb_before", wb.stb, 1);
    #1 rst_n = 1'b0;
    #1;
    check("rmw_cyc", wb.cyc, 0);
    check("rmw_stb", wb.stb, 0);
    check("rmw_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rmw_idle_busy", busy, 0);
    check("rmw_idle_stb", wb.stb, 0);
    $display("[TB] reset mid-write: stb=%0d busy=%0d", wb.stb, busy);
    run_vector(4, v[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/wfg_stim_sine_sweep_ctrl.md
# wfg_stim_sine_sweep_ctrl

Wishbone master that sequences the sine stimulus register block through a frequency sweep. On `start_i` it writes a start phase increment to INC.VAL and enables the generator via CTRL.EN. It then steps INC.VAL by a signed delta after each dwell period and disables the generator when the sweep finishes or is aborted. It sits between the top-level test/control logic and the sine stimulus register slave, and is the only master on that slave's bus segment.

## Interface

**Parameters**
- `BUSW`, 32: Wishbone data and address width.
- `INC_ADDR`, 32'h2: address of the INC register.
- `CTRL_ADDR`, 32'h1: address of the CTRL register.

**Ports**
- `wb_clk_i`, in, 1: clock.
- `wb_rst_ni`, in, 1: reset, asynchronous, active-low.
- `start_i`, in, 1: start sweep; single-cycle qualifier.
- `abort_i`, in, 1: abort the sweep in progress.
- `inc_start_i`, in, 16: first INC value.
- `inc_step_i`, in, 16: signed two's-complement delta per step.
- `steps_i`, in, 16: number of steps; the sweep writes `steps_i`+1 INC values.
- `dwell_i`, in, 24: cycles spent per INC value.
- `wbm_cyc_o` / `wbm_stb_o` / `wbm_we_o`, out, 1 each: Wishbone master controls.
- `wbm_sel_o`, out, BUSW/8: byte selects, always all-ones during a write.
- `wbm_adr_o`, out, BUSW: write address.
- `wbm_dat_o`, out, BUSW: write data.
- `wbm_ack_i`, in, 1: slave acknowledge.
- `busy_o`, out, 1: sweep in progress.
- `done_o`, out, 1: one-cycle pulse when the final CTRL=0 write is acknowledged.
- `cur_inc_o`, out, 16: INC value most recently written.
- `step_cnt_o`, out, 16: index of the current INC value.

## Operation

**States**
- **IDLE**
  - On `start_i` && !`abort_i`: latch all four config inputs; `inc`=`inc_start_i`; `cnt`=0; go to WR_INC.
  - `abort_i` in IDLE is ignored. If `start_i` and `abort_i` are high together, the start is dropped.
- **WR_INC**
  - Drive: `adr`=INC_ADDR, `dat`={16'b0, `inc`}, `we`=1.
  - On ack: update `cur_inc_o`. If `cnt`==0, go to WR_EN; otherwise go to DWELL.
- **WR_EN**: write CTRL_ADDR with data 1. On ack, go to DWELL.
- **DWELL**
  - Load the down-counter with max(`dwell_i`,1) on entry; the state lasts exactly that many cycles.
  - At expiry:
    - If `cnt`==`steps_i`, go to WR_DIS.
    - Otherwise: `inc` += `step`, modulo 2^16 (wrap, no saturation); `cnt`++; go to WR_INC.
- **WR_DIS**: write CTRL_ADDR with data 0. On ack, pulse `done_o` and go to IDLE.

**Bus rules**
- `cyc`, `stb` and `we` are asserted together and held until `wbm_ack_i` is sampled high.
- `wbm_ack_i` is qualified only while `stb` is high.
- After every ack, `stb` and `cyc` stay low for at least one cycle before the next transaction. This absorbs the slave's trailing ack, since the slave acks one cycle after each sampled stb and may ack twice.
- There is no timeout.

**Abort**
- Latched while busy.
- In DWELL: go to WR_DIS on the next cycle.
- In WR_INC or WR_EN: finish the transaction in flight, then go to WR_DIS.
- In WR_DIS: no effect.
- An abort always ends with exactly one CTRL=0 write and a `done_o` pulse.

**Other rules**
- `start_i` while busy is ignored.
- Config inputs are not re-sampled mid-sweep.
- `busy_o` is 1 in every state except IDLE.

## Timing

- **Reset values**: all outputs 0, state IDLE. Reset is asynchronous: `cyc`/`stb` drop immediately, even mid-transaction.
- **Start latency**: `start_i` sampled at edge k gives `busy_o`=1 and `stb`=1 in cycle k+1.
- **Write duration**: with the local register slave, each write holds `stb` for 2 cycles (ack arrives 1 cycle later), then 1 gap cycle.
- **INC-to-INC spacing**: rising edges of consecutive INC writes are max(`dwell_i`,1)+3 cycles apart.
- **Done timing**: `done_o` is high in the cycle after the WR_DIS ack; `busy_o` falls in the same cycle.

## Structure

- **Package `wfg_stim_sine_pkg`**:
  - state enum `sweep_state_e`;
  - register address constants `WFG_SINE_CTRL_ADDR` and `WFG_SINE_INC_ADDR`;
  - `DWELL_W`=24.
- **Sub-module `wfg_wb_master_wr`**:
  - Single-write Wishbone master: req/addr/data in, done out.
  - Owns the cyc/stb hold, ack qualification and the mandatory gap cycle.
  - Reusable by the other stimulus controllers.
- **Top level**: FSM, dwell counter, step counter and INC accumulator.

## Test plan

- **Basic sweep**: `inc_start`=0x1000, `step`=0x0100, `steps`=3, `dwell`=10 → bus writes INC 0x1000, CTRL 1, then INC 0x1100, 0x1200, 0x1300 at 13-cycle spacing, then CTRL 0. `done_o` pulses once. Slave reads back INC=0x1300, EN=0.
- **Negative step with wrap**: `inc_start`=0x0080, `step`=0xFF00, `steps`=1 → INC writes 0x0080 then 0xFF80.
- **Abort in DWELL**: abort in the DWELL after the second INC write → next transaction is CTRL 0; no further INC writes; `step_cnt_o`=1; `done_o` pulses.
- **Abort with stalled ack**: abort in WR_INC with the slave ack stalled 3 cycles → INC write completes, then CTRL 0, then `done_o`.
- **Degenerate sweep, start while busy**: `steps`=0, `dwell`=0 → INC, CTRL 1, 1-cycle dwell, CTRL 0. A second `start_i` while busy is ignored (no extra writes).
- **Reset mid-write**: assert `wb_rst_ni` low mid-WR_INC → `cyc`/`stb`/`busy_o` go low without a clock edge. After release, the FSM is in IDLE and a new start runs normally.
